pairing_host_bridge: RTL and testbench
======================================

// Module: pairing_host_bridge
// PURPOSE
//   Host-side sequencer in front of BN254_pairing. Accepts 256-bit operand words over a
//   valid/ready stream, splits each into redundant L3 limbs (carry=0) and writes it to
//   all four core RAM banks. It then pulses run and waits for the core to finish.
//   Finally it streams the RES_CNT result words back out. Replaces hand-driven bench/host load sequences.
// PARAMETERS
//   N_LIMB    4      limbs per word (ADD_DIV); WORD_W == N_LIMB*LIMB_W
//   LIMB_W    64     value bits per limb (fp_div4_t)
//   CARRY_W   3      carry bits per limb (L3_CARRY)
//   RD_W      289    core read-data width
//   SWRST_CYC 10     cycles swrst is held before loading
//   ARM_CYC   100    cycles after run pulse before busy is sampled
//   RD_LAT    2      core read latency, cycles from out_addr to valid out_data
//   RES_BASE  9'h10  first result address
//   RES_CNT   12     number of result words
// PORTS
//   clk          in  1                     clock
//   rstn         in  1                     async active-low reset
//   start        in  1                     begin session (honoured only in IDLE)
//   func         in  4                     n_func for this session, latched on start
//   s_valid      in  1                     operand word valid
//   s_ready      out 1                     operand word accepted when s_valid&s_ready
//   s_addr       in  7                     bank-local RAM address
//   s_data       in  N_LIMB*LIMB_W         operand, ordinary integer or Montgomery form
//   s_last       in  1                     last operand of session
//   m_valid      out 1                     result word valid
//   m_ready      in  1                     result consumer ready
//   m_data       out RD_W                  raw core output word
//   m_last       out 1                     marks result RES_CNT-1
//   sess_busy    out 1                     high outside IDLE
//   core_swrst   out 1                     to core swrst
//   core_run     out 1                     to core run (1-cycle pulse)
//   core_n_func  out 4                     to core n_func
//   core_busy    in  1                     from core busy
//   core_in_en   out 1                     to core extin_en
//   core_in_addr out 9                     to core extin_addr
//   core_in_data out N_LIMB*(LIMB_W+CARRY_W) to core extin_data
//   core_out_addr out 9                    to core extout_addr
//   core_out_data in  RD_W                 from core extout_data
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, counters 0; core_out_addr=0. rstn low mid-session aborts
//   instantly: no further in_en/run; stream handshakes drop; next session starts clean.
//   FSM: IDLE -start-> SWRST -SWRST_CYC cycles-> LOAD -accepted s_last and 4th bank write done->
//   RUN (1 cyc) -> ARM (ARM_CYC cyc) -> WAIT -core_busy==0-> READ -last word taken-> IDLE.
//   SWRST: core_swrst=1 throughout SWRST and LOAD; dropped on entry to RUN.
//   LOAD: s_ready=1 only when bank counter b==0. On accept, word/addr latched; for b=0..3 on
//   four consecutive cycles: core_in_en=1, core_in_addr={b[1:0],s_addr}, core_in_data limb i =
//   {CARRY_W'0, word[i*LIMB_W +: LIMB_W]}. Throughput 1 word / 4 cycles; s_ready re-asserts the
//   cycle after the b=3 write. Words without s_last simply continue LOAD; later same address overwrites.
//   RUN: core_run=1 for exactly one cycle; core_n_func=latched func, held until IDLE.
//   ARM: core_busy ignored (core raises busy late); WAIT: leave on first cycle core_busy==0.
//   READ: for k=0..RES_CNT-1: core_out_addr=RES_BASE+k, wait RD_LAT cycles, capture out_data into
//   m_data, m_valid=1 (m_last when k==RES_CNT-1); hold stable until m_ready; then k++. m_valid
//   drops the cycle after the final handshake; FSM returns to IDLE same edge.
//   start while not IDLE: ignored. s_valid outside LOAD: not accepted (s_ready=0).
//   sess_busy = (state!=IDLE).
// TESTING
//   1 reset: rstn low -> all outputs 0, s_ready=0, m_valid=0, sess_busy=0.
//   2 load: start,func=3; words 0x00=0x11095cf5...04ff, 0x0b=1 (last) -> in_en at addr 0x000,0x080,
//     0x100,0x180 then 0x00b,0x08b,0x10b,0x18b; limb0 of word 0x0b = 1, all carries 0; s_ready 1-in-4.
//   3 run/wait: core_busy model high 50 cycles after run, low 500 later -> exactly one run pulse,
//     n_func=3, READ entered the cycle after busy falls, not during ARM.
//   4 readback: core model returns addr*3 after RD_LAT=2 -> 12 words 0x30..0x51, m_last on 12th;
//     m_ready toggled 1/0 randomly -> no loss/duplicate, m_data stable while stalled.
//   5 abort: rstn low during 2nd bank write and again in READ -> in_en/m_valid 0 immediately;
//     fresh session afterwards matches scenario 2 exactly.
//   6 start ignored while sess_busy; s_valid in IDLE never handshakes.

Source files
------------

// File: rtl/pairing_host_bridge.sv
// rtl/pairing_host_bridge.sv - host sequencer: load operands into BN254_pairing, run it, stream results back
module pairing_host_bridge #(
    parameter int         N_LIMB    = 4,
    parameter int         LIMB_W    = 64,
    parameter int         CARRY_W   = 3,
    parameter int         RD_W      = 289,
    parameter int         SWRST_CYC = 10,
    parameter int         ARM_CYC   = 100,
    parameter int         RD_LAT    = 2,
    parameter logic [8:0] RES_BASE  = 9'h10,
    parameter int         RES_CNT   = 12
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 start,
    input  logic [3:0]                           func,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [6:0]                           s_addr,
    input  logic [N_LIMB*LIMB_W-1:0]             s_data,
    input  logic                                 s_last,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [RD_W-1:0]                      m_data,
    output logic                                 m_last,
    output logic                                 sess_busy,
    output logic                                 core_swrst,
    output logic                                 core_run,
    output logic [3:0]                           core_n_func,
    input  logic                                 core_busy,
    output logic                                 core_in_en,
    output logic [8:0]                           core_in_addr,
    output logic [N_LIMB*(LIMB_W+CARRY_W)-1:0]   core_in_data,
    output logic [8:0]                           core_out_addr,
    input  logic [RD_W-1:0]                      core_out_data
);
    localparam int WORD_W = N_LIMB * LIMB_W;
    localparam int L3_W   = LIMB_W + CARRY_W;
    localparam int CNT_W  = 16;
    localparam int K_W    = $clog2(RES_CNT);
    localparam int LAT_W  = $clog2(RD_LAT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SWRST = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_ARM   = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;
    localparam logic [2:0] S_READ  = 3'd6;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        bank;
    logic [WORD_W-1:0] word_q;
    logic [6:0]        addr_q;
    logic              last_q;
    logic [3:0]        func_q;
    logic [K_W-1:0]    k;
    logic [LAT_W-1:0]  lat;
    logic              m_valid_q;
    logic [RD_W-1:0]   m_data_q;

    logic              accept;
    logic [WORD_W-1:0] wr_word;
    logic [6:0]        wr_addr;

    // Bank 0 is written in the accept cycle straight from the stream, banks 1..3 from the latch
    assign s_ready = (state == S_LOAD) && (bank == 2'd0);
    assign accept  = s_ready && s_valid;
    assign wr_word = (bank == 2'd0) ? s_data : word_q;
    assign wr_addr = (bank == 2'd0) ? s_addr : addr_q;

    assign core_in_en    = (state == S_LOAD) && ((bank != 2'd0) || s_valid);
    assign core_in_addr  = core_in_en ? {bank, wr_addr} : 9'd0;
    assign core_swrst    = (state == S_SWRST) || (state == S_LOAD);
    assign core_run      = (state == S_RUN);
    assign sess_busy     = (state != S_IDLE);
    assign core_n_func   = sess_busy ? func_q : 4'd0;
    assign core_out_addr = (state == S_READ) ? RES_BASE + 9'(k) : 9'd0;
    assign m_valid       = m_valid_q;
    assign m_data        = m_data_q;
    assign m_last        = m_valid_q && (k == K_W'(RES_CNT - 1));

    always_comb begin
        core_in_data = '0;
        if (core_in_en) begin
            for (int i = 0; i < N_LIMB; i++) begin
                core_in_data[i*L3_W +: L3_W] = {{CARRY_W{1'b0}}, wr_word[i*LIMB_W +: LIMB_W]};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bank      <= 2'd0;
            word_q    <= '0;
            addr_q    <= 7'd0;
            last_q    <= 1'b0;
            func_q    <= 4'd0;
            k         <= '0;
            lat       <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        func_q <= func;
                        cnt    <= '0;
                        bank   <= 2'd0;
                        state  <= S_SWRST;
                    end
                end
                S_SWRST: begin
                    if (cnt == CNT_W'(SWRST_CYC - 1)) begin
                        cnt   <= '0;
                        state <= S_LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        word_q <= s_data;
                        addr_q <= s_addr;
                        last_q <= s_last;
                        bank   <= 2'd1;
                    end else if (bank != 2'd0) begin
                        bank <= bank + 2'd1;
                        if (bank == 2'd3 && last_q) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    cnt   <= '0;
                    state <= S_ARM;
                end
                S_ARM: begin
                    // The core raises busy some time after run, so busy is not trusted here
                    if (cnt == CNT_W'(ARM_CYC - 1)) begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!core_busy) begin
                        k         <= '0;
                        lat       <= '0;
                        m_valid_q <= 1'b0;
                        state     <= S_READ;
                    end
                end
                S_READ: begin
                    if (!m_valid_q) begin
                        if (lat == LAT_W'(RD_LAT)) begin
                            m_data_q  <= core_out_data;
                            m_valid_q <= 1'b1;
                            lat       <= '0;
                        end else begin
                            lat <= lat + 1'b1;
                        end
                    end else if (m_ready) begin
                        m_valid_q <= 1'b0;
                        if (k == K_W'(RES_CNT - 1)) begin
                            k     <= '0;
                            state <= S_IDLE;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pairing_host_bridge.sv
// tb/tb_pairing_host_bridge.sv - directed/random bench for pairing_host_bridge with core and scoreboard model
module tb_pairing_host_bridge;
    localparam int RD_W    = 289;
    localparam int IN_W    = 268;
    localparam int RES_CNT = 12;
    localparam logic [255:0] W0 =
        256'h11095cf5_2d3a8e41_77c0b9a6_5e13f2d8_9a0c4b71_e6d52f38_0b7a91c4_3f6e04ff;

    typedef struct packed {
        logic [8:0]      a;
        logic [IN_W-1:0] d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [3:0]        func;
    logic              s_valid;
    logic              s_ready;
    logic [6:0]        s_addr;
    logic [255:0]      s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [RD_W-1:0]   m_data;
    logic              m_last;
    logic              sess_busy;
    logic              core_swrst;
    logic              core_run;
    logic [3:0]        core_n_func;
    logic              core_busy;
    logic              core_in_en;
    logic [8:0]        core_in_addr;
    logic [IN_W-1:0]   core_in_data;
    logic [8:0]        core_out_addr;
    logic [RD_W-1:0]   core_out_data;

    pairing_host_bridge dut (
        .clk(clk), .rstn(rstn), .start(start), .func(func),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .sess_busy(sess_busy), .core_swrst(core_swrst), .core_run(core_run),
        .core_n_func(core_n_func), .core_busy(core_busy), .core_in_en(core_in_en),
        .core_in_addr(core_in_addr), .core_in_data(core_in_data),
        .core_out_addr(core_out_addr), .core_out_data(core_out_data)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          run_at = -100000;
    int          run_cnt = 0;
    int          read_at = 0;
    logic [3:0]  run_func = 4'd0;
    logic [8:0]  prev_oa = 9'd0;
    logic [RD_W-1:0] d1, d2;
    wr_t         got_wr[$];
    int          acc_cyc[$];
    logic [255:0] wq[$];
    logic [6:0]   aq[$];

    // Core model: busy window 50..549 cycles after run, reads are three half-cycle-late stages
    initial begin
        wr_t w;
        core_busy = 1'b0;
        core_out_data = '0;
        d1 = '0;
        d2 = '0;
        forever begin
            @(negedge clk);
            if (core_in_en) begin
                w = {core_in_addr, core_in_data};
                got_wr.push_back(w);
            end
            if (s_valid && s_ready) acc_cyc.push_back(cyc);
            if (core_run) begin
                run_cnt++;
                run_at = cyc;
                run_func = core_n_func;
            end
            if (prev_oa == 9'd0 && core_out_addr != 9'd0) read_at = cyc;
            prev_oa = core_out_addr;
            core_busy = (cyc - run_at >= 50) && (cyc - run_at < 550);
            core_out_data = d2;
            d2 = d1;
            d1 = {280'd0, core_out_addr} * 289'd3;
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] l3(input logic [255:0] w);
        logic [IN_W-1:0] r;
        for (int i = 0; i < 4; i++) r[i*67 +: 67] = {3'b000, w[i*64 +: 64]};
        return r;
    endfunction

    task automatic send_word(input int j);
        logic ok;
        s_valid = 1'b1;
        s_data  = wq[j];
        s_addr  = aq[j];
        s_last  = (j == wq.size() - 1);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("s_ready_timeout", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic read_results();
        int got;
        logic held_v;
        logic [RD_W-1:0] held_d;
        got = 0;
        held_v = 1'b0;
        held_d = '0;
        for (int c = 0; c < 800 && got < RES_CNT; c++) begin
            @(negedge clk);
            if (held_v) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, held_d);
            end
            m_ready = 1'($urandom_range(0, 1));
            if (m_valid && m_ready) begin
                check($sformatf("rd_data%0d", got), m_data, 300'((16 + got) * 3));
                check($sformatf("rd_last%0d", got), m_last, (got == RES_CNT - 1));
                got++;
                held_v = 1'b0;
            end else if (m_valid) begin
                held_v = 1'b1;
                held_d = m_data;
            end
        end
        check("rd_count", got, RES_CNT);
        @(negedge clk);
        m_ready = 1'b0;
        check("rd_valid_drop", m_valid, 0);
        check("rd_idle", sess_busy, 0);
    endtask

    task automatic session(input logic [3:0] f, input bit abort_read);
        int gw0, rc0, ac0, n;
        logic ok;
        gw0 = got_wr.size();
        rc0 = run_cnt;
        ac0 = acc_cyc.size();
        n = wq.size();
        start = 1'b1;
        func = f;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", sess_busy, 1);
        check("swrst_after_start", core_swrst, 1);
        start = 1'b1;
        func = ~f;
        @(posedge clk);
        #1;
        start = 1'b0;
        func = 4'd0;
        for (int j = 0; j < n; j++) send_word(j);
        s_valid = 1'b0;
        s_last = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (core_out_addr != 9'd0) begin
                ok = 1'b1;
                break;
            end
        end
        check("read_entry_timeout", ok, 1);
        check("n_func_held", core_n_func, f);
        check("swrst_dropped", core_swrst, 0);
        check("wr_count", got_wr.size() - gw0, 4 * n);
        for (int j = 0; j < n; j++) begin
            for (int b = 0; b < 4; b++) begin
                wr_t e, g;
                e = {2'(b), aq[j], l3(wq[j])};
                g = (gw0 + j*4 + b < got_wr.size()) ? got_wr[gw0 + j*4 + b] : '0;
                check($sformatf("wr%0d_b%0d", j, b), g, e);
            end
        end
        for (int j = 0; j + 1 < n; j++)
            check("accept_spacing", acc_cyc[ac0 + j + 1] - acc_cyc[ac0 + j], 4);
        check("run_pulses", run_cnt - rc0, 1);
        check("run_func", run_func, f);
        if (abort_read) begin
            ok = 1'b0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (m_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("abort_rd_wait", ok, 1);
            rstn = 1'b0;
            #1;
            check("abort_rd_m_valid", m_valid, 0);
            check("abort_rd_out_addr", core_out_addr, 0);
            check("abort_rd_busy", sess_busy, 0);
            repeat (2) @(negedge clk);
            rstn = 1'b1;
            repeat (2) @(negedge clk);
        end else begin
            read_results();
            check("read_after_busy_fall", read_at - run_at, 551);
        end
    endtask

    task automatic abort_load();
        int gw0, rc0;
        gw0 = got_wr.size();
        rc0 = run_cnt;
        start = 1'b1;
        func = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_word(0);
        check("abort_ld_pre_en", core_in_en, 1);
        rstn = 1'b0;
        #1;
        check("abort_ld_en", core_in_en, 0);
        check("abort_ld_addr", core_in_addr, 0);
        check("abort_ld_ready", s_ready, 0);
        check("abort_ld_swrst", core_swrst, 0);
        check("abort_ld_busy", sess_busy, 0);
        s_valid = 1'b0;
        s_last = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_ld_writes", got_wr.size() - gw0, 1);
        check("abort_ld_no_run", run_cnt - rc0, 0);
    endtask

    task automatic set_directed();
        wq.delete();
        aq.delete();
        wq.push_back(W0);
        aq.push_back(7'h00);
        wq.push_back(256'd1);
        aq.push_back(7'h0b);
    endtask

    task automatic set_random(input int n);
        wq.delete();
        aq.delete();
        for (int j = 0; j < n; j++) begin
            wq.push_back({$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom});
            aq.push_back(7'($urandom_range(0, 127)));
        end
    endtask

    initial begin
        int n0;
        rstn = 1'b0;
        start = 1'b0;
        func = 4'd0;
        s_valid = 1'b0;
        s_addr = 7'd0;
        s_data = '0;
        s_last = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sess_busy", sess_busy, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_ctrl", {core_swrst, core_run, core_in_en, m_last, core_n_func}, 0);
        check("rst_addrs", {core_in_addr, core_out_addr}, 0);
        check("rst_in_data", core_in_data, 0);
        check("rst_m_data", m_data, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        n0 = acc_cyc.size();
        s_valid = 1'b1;
        s_data = {8{$urandom}};
        repeat (5) begin
            @(negedge clk);
            check("idle_s_ready", s_ready, 0);
        end
        s_valid = 1'b0;
        @(negedge clk);
        check("idle_accepts", acc_cyc.size() - n0, 0);

        set_directed();
        session(4'd3, 1'b0);
        set_random(3);
        session(4'($urandom_range(0, 15)), 1'b0);
        set_directed();
        abort_load();
        session(4'd3, 1'b0);
        set_random(2);
        session(4'($urandom_range(0, 15)), 1'b1);
        set_random(1);
        session(4'($urandom_range(0, 15)), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
